vend_ctrl: RTL

Transaction controller for the vending machine. It accumulates inserted coins into a credit register and releases the item when credit covers the price. It then sequences the downstream coin dispenser: it drives the dispenser's `change` bus and counts the quarter/dime/nickel pulses returned until the owed amount is paid out. It sits between the coin-acceptor front end and the coin dispenser, and owns the machine's only credit/change state.

---
 rtl/vend_pkg.sv | 37 +++
 rtl/vend_ctrl_if.sv | 42 ++++
 rtl/vend_ctrl_change_tracker.sv | 79 +++++++
 rtl/vend_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the vending transaction controller.
//   CENTS_W             : width of every money quantity (cents, unsigned)
//   NICKEL/DIME/QUARTER : coin values in cents
//   state_t             : controller state encoding
//   coin_value()        : total cents of a {quarter,dime,nickel} pulse vector
//   coin_count()        : number of pulses set in a {quarter,dime,nickel} vector
package vend_pkg;

  localparam int CENTS_W = 10;

  localparam logic [CENTS_W-1:0] NICKEL  = 10'd5;
  localparam logic [CENTS_W-1:0] DIME    = 10'd10;
  localparam logic [CENTS_W-1:0] QUARTER = 10'd25;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CREDIT = 3'd1,
    ST_VEND   = 3'd2,
    ST_CHANGE = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  // c = {quarter, dime, nickel}; simultaneous pulses are summed.
  function automatic logic [CENTS_W-1:0] coin_value(input logic [2:0] c);
    logic [CENTS_W-1:0] v;
    v = '0;
    if (c[0]) v = v + NICKEL;
    if (c[1]) v = v + DIME;
    if (c[2]) v = v + QUARTER;
    return v;
  endfunction

  function automatic logic [1:0] coin_count(input logic [2:0] c);
    return {1'b0, c[0]} + {1'b0, c[1]} + {1'b0, c[2]};
  endfunction

endpackage

// File: rtl/vend_ctrl_if.sv
// Signal bundle between the controller, the coin-acceptor front end and the
// coin dispenser.
//   coin_n/coin_d/coin_q          : accepted-coin pulses from the acceptor
//   vend_req/cancel               : user requests
//   outquarter/outdime/outnickel  : coin-ejected pulses from the dispenser
//   change                        : cents still owed, to the dispenser
//   credit                        : current credit in cents
//   item_out/coin_reject          : one-cycle status pulses
//   busy/fault                    : transaction busy, sticky dispenser fault
// slave  : controller side
// master : environment side (acceptor, dispenser, user panel)
interface vend_ctrl_if;
  import vend_pkg::*;

  logic               coin_n;
  logic               coin_d;
  logic               coin_q;
  logic               vend_req;
  logic               cancel;
  logic               outquarter;
  logic               outdime;
  logic               outnickel;
  logic [CENTS_W-1:0] change;
  logic [CENTS_W-1:0] credit;
  logic               item_out;
  logic               coin_reject;
  logic               busy;
  logic               fault;

  modport slave (
    input  coin_n, coin_d, coin_q, vend_req, cancel,
    input  outquarter, outdime, outnickel,
    output change, credit, item_out, coin_reject, busy, fault
  );

  modport master (
    output coin_n, coin_d, coin_q, vend_req, cancel,
    output outquarter, outdime, outnickel,
    input  change, credit, item_out, coin_reject, busy, fault
  );

endinterface

// File: rtl/vend_ctrl_change_tracker.sv
// Remaining-change bookkeeping for the payout phase.
//   clk, rst_n        : clock, asynchronous active-low reset
//   load_i/load_val_i : load the amount owed (entry to payout)
//   active_i          : controller is in the payout state
//   out*_i            : dispenser coin-ejected pulses
//   remain_o          : registered amount still owed
//   done_o            : this cycle's pulses pay off the remainder exactly
//   err_o             : pulse sum exceeds remainder, or dispenser went silent
//                       for TIMEOUT consecutive cycles
// done_o/err_o are combinational so the controller changes state on the same
// edge that the remainder is updated.
module change_tracker
  import vend_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [CENTS_W-1:0] load_val_i,
  input  logic               active_i,
  input  logic               outquarter_i,
  input  logic               outdime_i,
  input  logic               outnickel_i,
  output logic [CENTS_W-1:0] remain_o,
  output logic               done_o,
  output logic               err_o
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic [CENTS_W-1:0] remain_q, remain_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [CENTS_W-1:0] pulse_sum;
  logic               any_pulse;
  logic               underflow;
  logic               timeout;

  assign pulse_sum = coin_value({outquarter_i, outdime_i, outnickel_i});
  assign any_pulse = outquarter_i | outdime_i | outnickel_i;
  assign underflow = active_i && any_pulse && (pulse_sum > remain_q);
  // Silent cycle number TIMEOUT is the one that trips the fault.
  assign timeout   = active_i && !any_pulse && (tmo_q == TMO_LAST);
  assign err_o     = underflow | timeout;
  assign done_o    = active_i && any_pulse && !underflow && (pulse_sum == remain_q);
  assign remain_o  = remain_q;

  always_comb begin
    remain_d = remain_q;
    tmo_d    = tmo_q;
    if (load_i) begin
      remain_d = load_val_i;
      tmo_d    = '0;
    end else if (active_i) begin
      if (err_o) begin
        // Never let a faulted payout leave a wrapped or stale amount owed.
        remain_d = '0;
        tmo_d    = '0;
      end else if (any_pulse) begin
        remain_d = remain_q - pulse_sum;
        tmo_d    = '0;
      end else begin
        tmo_d    = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remain_q <= '0;
      tmo_q    <= '0;
    end else begin
      remain_q <= remain_d;
      tmo_q    <= tmo_d;
    end
  end

endmodule

// File: rtl/vend_ctrl.sv
// Vending transaction controller: accumulates coin credit, releases the item
// when credit covers PRICE, then drives the dispenser until the change owed
// is paid out.
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : vend_ctrl_if.slave (coins, requests, dispenser pulses, status)
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE      = 65,
  parameter int MAX_CREDIT = 995,
  parameter int TIMEOUT    = 64
) (
  input logic        clk,
  input logic        rst,
  vend_ctrl_if.slave bus
);

  localparam logic [CENTS_W-1:0] PRICE_C = CENTS_W'(PRICE);
  localparam logic [CENTS_W:0]   MAX_C   = (CENTS_W + 1)'(MAX_CREDIT);

  state_t             state_q;
  logic [CENTS_W-1:0] credit_q;
  logic               item_out_q;
  logic               coin_reject_q;
  logic               busy_q;
  logic               fault_q;

  logic [2:0]         coins;
  logic               any_coin;
  logic               coin_ok;
  logic [CENTS_W:0]   credit_sum;
  logic               req_cancel;
  logic               req_vend;
  logic [CENTS_W-1:0] vend_remain;

  logic               trk_load;
  logic [CENTS_W-1:0] trk_load_val;
  logic [CENTS_W-1:0] trk_remain;
  logic               trk_done;
  logic               trk_err;

  assign coins      = {bus.coin_q, bus.coin_d, bus.coin_n};
  assign any_coin   = |coins;
  // One extra bit so a sum past the ceiling cannot wrap below it.
  assign credit_sum = {1'b0, credit_q} + {1'b0, coin_value(coins)};
  assign coin_ok    = any_coin && (coin_count(coins) == 2'd1) && (credit_sum <= MAX_C);

  // Requests only exist in CREDIT; cancel outranks vend.
  assign req_cancel  = (state_q == ST_CREDIT) && bus.cancel;
  assign req_vend    = (state_q == ST_CREDIT) && !bus.cancel && bus.vend_req &&
                       (credit_q >= PRICE_C);
  assign vend_remain = credit_q - PRICE_C;

  // Payout amount is loaded on the edge that enters CHANGE.
  assign trk_load     = req_cancel || (state_q == ST_VEND);
  assign trk_load_val = req_cancel ? credit_q : vend_remain;

  change_tracker #(
    .TIMEOUT (TIMEOUT)
  ) u_tracker (
    .clk          (clk),
    .rst_n        (rst),
    .load_i       (trk_load),
    .load_val_i   (trk_load_val),
    .active_i     (state_q == ST_CHANGE),
    .outquarter_i (bus.outquarter),
    .outdime_i    (bus.outdime),
    .outnickel_i  (bus.outnickel),
    .remain_o     (trk_remain),
    .done_o       (trk_done),
    .err_o        (trk_err)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      credit_q      <= '0;
      item_out_q    <= 1'b0;
      coin_reject_q <= 1'b0;
      busy_q        <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      item_out_q    <= 1'b0;
      coin_reject_q <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_CREDIT: begin
          if (req_cancel) begin
            credit_q      <= '0;
            busy_q        <= 1'b1;
            coin_reject_q <= any_coin;
            state_q       <= ST_CHANGE;
          end else if (req_vend) begin
            busy_q        <= 1'b1;
            item_out_q    <= 1'b1;
            coin_reject_q <= any_coin;
            state_q       <= ST_VEND;
          end else if (coin_ok) begin
            credit_q      <= credit_sum[CENTS_W-1:0];
            state_q       <= ST_CREDIT;
          end else begin
            coin_reject_q <= any_coin;
          end
        end
        ST_VEND: begin
          credit_q      <= '0;
          coin_reject_q <= any_coin;
          if (vend_remain != '0) begin
            state_q <= ST_CHANGE;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_CHANGE: begin
          coin_reject_q <= any_coin;
          if (trk_err) begin
            fault_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_FAULT;
          end else if (trk_done) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_FAULT: begin
          coin_reject_q <= any_coin;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.change      = trk_remain;
  assign bus.credit      = credit_q;
  assign bus.item_out    = item_out_q;
  assign bus.coin_reject = coin_reject_q;
  assign bus.busy        = busy_q;
  assign bus.fault       = fault_q;

endmodule
